// File: rtl/alu_op_issuer.sv
// Command front end for a registered ALU: queues requests, issues them to the ALU,
// captures the result one clock after the ALU samples it, and returns it with the request tag.
module alu_op_issuer #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 4,
   parameter int TAG_W = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       cmd_valid,
   output logic                       cmd_ready,
   input  logic [2:0]                 cmd_op,
   input  logic [WIDTH-1:0]           cmd_a,
   input  logic [WIDTH-1:0]           cmd_b,
   input  logic [TAG_W-1:0]           cmd_tag,
   output logic [WIDTH-1:0]           alu_a,
   output logic [WIDTH-1:0]           alu_b,
   output logic [2:0]                 alu_ctrl,
   input  logic [WIDTH-1:0]           alu_result,
   output logic                       rsp_valid,
   input  logic                       rsp_ready,
   output logic [WIDTH-1:0]           rsp_result,
   output logic [TAG_W-1:0]           rsp_tag,
   output logic                       rsp_illegal,
   output logic                       busy,
   output logic [$clog2(DEPTH):0]     count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   typedef struct packed {
      logic [2:0]       op;
      logic [WIDTH-1:0] a;
      logic [WIDTH-1:0] b;
      logic [TAG_W-1:0] tag;
   } cmd_t;

   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT,
      S_CAP,
      S_RESP
   } state_t;

   state_t           state_q, state_d;
   cmd_t             mem [DEPTH];
   cmd_t             head;
   logic [PW-1:0]    wr_ptr, rd_ptr;
   logic             push, pop, cap_en, rsp_clr;
   logic [TAG_W-1:0] tag_q;
   logic             illegal_q;

   // Full check uses only the registered count, so a same-cycle pop never frees a slot early.
   assign cmd_ready = (count < CW'(DEPTH));
   assign push      = cmd_valid && cmd_ready;
   assign head      = mem[rd_ptr];
   assign busy      = (state_q != S_IDLE) || (count != '0);

   // NOTE: sequential state is written with non-blocking assignments so every register
   // samples pre-edge values, independent of the order the always blocks are evaluated.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // NOTE: the storage array has no reset; the pointers and count alone define which
   // entries are valid, so clearing the data would only add reset fan-out.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= '{op: cmd_op, a: cmd_a, b: cmd_b, tag: cmd_tag};
   end

   always_ff @(posedge clk) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   // NOTE: every signal assigned in always_comb gets a default first, so no path
   // through the case can leave it unassigned and infer a latch.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: if (count != '0) state_d = S_WAIT;
         S_WAIT: state_d = S_CAP;
         S_CAP:  state_d = S_RESP;
         S_RESP: if (rsp_ready) state_d = (count != '0) ? S_WAIT : S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      pop     = 1'b0;
      cap_en  = 1'b0;
      rsp_clr = 1'b0;
      case (state_q)
         S_IDLE: pop = (count != '0);
         S_CAP:  cap_en = 1'b1;
         S_RESP: begin
            rsp_clr = rsp_ready;
            pop     = rsp_ready && (count != '0);
         end
         default: ;
      endcase
   end

   // ALU operand registers change only on a pop; the tag and illegal flag travel alongside.
   always_ff @(posedge clk) begin
      if (rst) begin
         alu_a       <= '0;
         alu_b       <= '0;
         alu_ctrl    <= '0;
         tag_q       <= '0;
         illegal_q   <= 1'b0;
         rsp_valid   <= 1'b0;
         rsp_result  <= '0;
         rsp_tag     <= '0;
         rsp_illegal <= 1'b0;
      end else begin
         if (pop) begin
            alu_a     <= head.a;
            alu_b     <= head.b;
            alu_ctrl  <= head.op;
            tag_q     <= head.tag;
            illegal_q <= (head.op >= 3'd5);
         end
         if (cap_en) begin
            rsp_result  <= alu_result;
            rsp_tag     <= tag_q;
            rsp_illegal <= illegal_q;
            rsp_valid   <= 1'b1;
         end else if (rsp_clr) begin
            rsp_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_alu_op_issuer.sv
// Directed bench for alu_op_issuer; includes a behavioural registered ALU sharing clk/rst.
module tb_alu_op_issuer;

   localparam int WIDTH = 32;
   localparam int DEPTH = 4;
   localparam int TAG_W = 4;

   logic             clk = 1'b0;
   logic             rst;
   logic             cmd_valid;
   logic             cmd_ready;
   logic [2:0]       cmd_op;
   logic [WIDTH-1:0] cmd_a, cmd_b;
   logic [TAG_W-1:0] cmd_tag;
   logic [WIDTH-1:0] alu_a, alu_b, alu_result;
   logic [2:0]       alu_ctrl;
   logic             rsp_valid, rsp_ready, rsp_illegal, busy;
   logic [WIDTH-1:0] rsp_result;
   logic [TAG_W-1:0] rsp_tag;
   logic [$clog2(DEPTH):0] count;

   int errors = 0;
   int checks = 0;
   int pushed, got;
   logic hs, rs, seen;

   always #5 clk = ~clk;

   alu_op_issuer #(.WIDTH(WIDTH), .DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
      .clk(clk), .rst(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
      .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_tag(cmd_tag),
      .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl), .alu_result(alu_result),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
      .rsp_tag(rsp_tag), .rsp_illegal(rsp_illegal), .busy(busy), .count(count)
   );

   // Registered ALU with one clock of latency; illegal opcodes yield zero.
   always_ff @(posedge clk) begin
      if (rst) alu_result <= '0;
      else begin
         case (alu_ctrl)
            3'b000:  alu_result <= alu_a + alu_b;
            3'b001:  alu_result <= alu_a - alu_b;
            3'b010:  alu_result <= alu_a & alu_b;
            3'b011:  alu_result <= alu_a | alu_b;
            3'b100:  alu_result <= ~alu_a;
            default: alu_result <= '0;
         endcase
      end
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_cmd(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [3:0] tag);
      cmd_valid = 1'b1;
      cmd_op    = op;
      cmd_a     = a;
      cmd_b     = b;
      cmd_tag   = tag;
   endtask

   task automatic wait_valid(input string tag, input int max_cycles);
      for (int i = 0; i < max_cycles; i++) begin
         if (rsp_valid) break;
         step();
      end
      check(tag, 64'(rsp_valid), 64'd1);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_a = '0; cmd_b = '0; cmd_tag = '0;
      rsp_ready = 1'b0;
      step(); step();
      rst = 1'b0;
      check("reset_rsp", {rsp_valid, rsp_illegal, rsp_result, rsp_tag}, 64'd0);
      check("reset_alu", {alu_ctrl, alu_a}, 64'd0);
      check("reset_count_busy", {count, busy}, 64'd0);
      check("reset_ready", 64'(cmd_ready), 64'd1);

      // 1: single add, observe latency and busy
      set_cmd(3'b000, 32'd5, 32'd7, 4'd3);
      step();                                  // T: push
      cmd_valid = 1'b0;
      check("t1_count_T", 64'(count), 64'd1);
      check("t1_busy_T", 64'(busy), 64'd1);
      step();                                  // T+1: pop
      check("t1_alu_ops", {alu_ctrl, alu_a, alu_b}, {35'd0, 32'd5} << 32 | 64'd7);
      check("t1_count_pop", 64'(count), 64'd0);
      step();                                  // T+2: ALU samples
      check("t1_valid_T2", 64'(rsp_valid), 64'd0);
      check("t1_busy_T2", 64'(busy), 64'd1);
      step();                                  // T+3: capture
      check("t1_valid_T3", 64'(rsp_valid), 64'd1);
      check("t1_result", 64'(rsp_result), 64'd12);
      check("t1_tag_ill", {rsp_tag, rsp_illegal}, {4'd3, 1'b0});
      rsp_ready = 1'b1;
      step();
      check("t1_valid_drop", 64'(rsp_valid), 64'd0);
      check("t1_busy_end", 64'(busy), 64'd0);

      // 2: back-to-back sub and not, three cycles apart
      set_cmd(3'b001, 32'd3, 32'd5, 4'd1);
      step();
      set_cmd(3'b100, 32'h0F0F0F0F, 32'd0, 4'd2);
      step();
      cmd_valid = 1'b0;
      step();
      check("t2_valid_early", 64'(rsp_valid), 64'd0);
      step();
      check("t2_rsp1", {rsp_valid, rsp_tag, rsp_result}, {1'b1, 4'd1, 32'hFFFFFFFE});
      step();
      check("t2_gap1", 64'(rsp_valid), 64'd0);
      check("t2_issue2", {alu_ctrl, alu_a}, {3'd4, 32'h0F0F0F0F});
      step();
      check("t2_gap2", 64'(rsp_valid), 64'd0);
      step();
      check("t2_rsp2", {rsp_valid, rsp_tag, rsp_result}, {1'b1, 4'd2, 32'hF0F0F0F0});
      step();
      check("t2_idle", {rsp_valid, busy}, 64'd0);

      // 3: back-pressure fills the FIFO, then drain in order
      rsp_ready = 1'b0;
      pushed = 0;
      for (int i = 0; i < 8; i++) begin
         if (pushed < 6) set_cmd(3'b000, 32'(pushed), 32'h100, 4'(pushed));
         else cmd_valid = 1'b0;
         hs = cmd_valid && cmd_ready;
         step();
         if (hs) pushed++;
      end
      check("t3_pushed_before_drain", 64'(pushed), 64'd5);
      check("t3_count_full", 64'(count), 64'd4);
      check("t3_ready_low", 64'(cmd_ready), 64'd0);
      check("t3_head_rsp", {rsp_valid, rsp_tag}, {1'b1, 4'd0});
      rsp_ready = 1'b1;
      got = 0;
      for (int i = 0; i < 40 && got < 6; i++) begin
         if (pushed < 6) set_cmd(3'b000, 32'(pushed), 32'h100, 4'(pushed));
         else cmd_valid = 1'b0;
         hs = cmd_valid && cmd_ready;
         rs = rsp_valid && rsp_ready;
         if (rs) begin
            check("t3_order_tag", 64'(rsp_tag), 64'(got));
            check("t3_order_result", 64'(rsp_result), 64'(32'h100 + got));
         end
         step();
         if (hs) pushed++;
         if (rs) got++;
      end
      cmd_valid = 1'b0;
      check("t3_rsp_count", 64'(got), 64'd6);

      // 4: illegal opcode issued unchanged
      step(); step();
      set_cmd(3'b110, 32'd1, 32'd1, 4'd9);
      step();
      cmd_valid = 1'b0;
      step();
      check("t4_alu_ctrl", 64'(alu_ctrl), 64'd6);
      wait_valid("t4_valid", 10);
      check("t4_rsp", {rsp_illegal, rsp_tag, rsp_result}, {1'b1, 4'd9, 32'd0});

      // 5: wrap-around add held under back-pressure
      step();
      rsp_ready = 1'b0;
      set_cmd(3'b000, 32'hFFFFFFFF, 32'd2, 4'd7);
      step();
      cmd_valid = 1'b0;
      wait_valid("t5_valid", 10);
      check("t5_rsp", {rsp_illegal, rsp_tag, rsp_result}, {1'b0, 4'd7, 32'd1});
      for (int i = 0; i < 10; i++) begin
         step();
         check("t5_hold", {rsp_valid, rsp_tag, rsp_result}, {1'b1, 4'd7, 32'd1});
      end
      rsp_ready = 1'b1;
      step();
      rsp_ready = 1'b0;
      check("t5_drop", {rsp_valid, busy}, 64'd0);

      // 6: reset while WAIT with two commands queued
      set_cmd(3'b000, 32'd1, 32'd1, 4'd10);
      step();
      set_cmd(3'b000, 32'h11, 32'd1, 4'd11);
      step();
      set_cmd(3'b000, 32'h12, 32'd1, 4'd12);
      step();
      cmd_valid = 1'b0;
      step();
      check("t6_rsp10", {rsp_valid, rsp_tag, rsp_result}, {1'b1, 4'd10, 32'd2});
      check("t6_queued", 64'(count), 64'd2);
      rsp_ready = 1'b1;
      set_cmd(3'b000, 32'h13, 32'd1, 4'd13);
      step();                                  // pop 11 and push 13 together
      cmd_valid = 1'b0;
      check("t6_push_pop_count", 64'(count), 64'd2);
      check("t6_issue11", {rsp_valid, alu_a}, {1'b0, 32'h11});
      rst = 1'b1;
      step();
      rst = 1'b0;
      check("t6_rst_rsp", {rsp_valid, rsp_illegal, rsp_result, rsp_tag}, 64'd0);
      check("t6_rst_alu", {alu_ctrl, alu_a, alu_b}, 64'd0);
      check("t6_rst_count_busy", {count, busy}, 64'd0);
      seen = 1'b0;
      for (int i = 0; i < 12; i++) begin
         step();
         seen = seen | rsp_valid;
      end
      check("t6_no_rsp", 64'(seen), 64'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/alu_op_issuer.md
Name: alu_op_issuer

Overview:
- Command-side front end for the registered ALU: queues operation requests, drives the ALU operand/opcode inputs, captures the ALU result after its one-clock latency, and returns it on a valid/ready response channel with a tag.
- Sits between the pipeline/controller and the ALU.
- Must share clk and rst with the ALU instance it drives.

Parameters:
- WIDTH, 32, operand/result width.
- DEPTH, 4, command FIFO entries (power of two, >=2).
- TAG_W, 4, tag width.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  FIFO can accept
- cmd_op  in  3  opcode: 000 add, 001 sub, 010 and, 011 or, 100 not A; 101-111 illegal
- cmd_a  in  WIDTH  operand A
- cmd_b  in  WIDTH  operand B
- cmd_tag  in  TAG_W  request tag
- alu_a  out  WIDTH  to ALU A
- alu_b  out  WIDTH  to ALU B
- alu_ctrl  out  3  to ALU alu_ctrl
- alu_result  in  WIDTH  from ALU result
- rsp_valid  out  1  response available
- rsp_ready  in  1  consumer accepts
- rsp_result  out  WIDTH  captured result
- rsp_tag  out  TAG_W  tag of response
- rsp_illegal  out  1  opcode was 101-111
- busy  out  1  state != IDLE or FIFO non-empty
- count  out  $clog2(DEPTH)+1  FIFO occupancy

Behaviour:
- Reset (rst is synchronous, active-high; clock is clk): FIFO pointers/count = 0, state = IDLE; rsp_valid, rsp_result, rsp_tag, rsp_illegal, alu_a, alu_b, alu_ctrl all 0; busy 0. Queued and in-flight commands are discarded, and no response for them ever appears.
- FIFO: push on cmd_valid && cmd_ready, storing {op, a, b, tag}. cmd_ready = (count < DEPTH), independent of any same-cycle pop; no push when full, even if a pop occurs that cycle. A pop occurs only when the FSM takes the head. count updates +1 / -1 / 0 for push / pop / both. Pointers wrap modulo DEPTH.
- FSM states and transitions:
  - IDLE: if count != 0, pop the head; register alu_a, alu_b, alu_ctrl = head.a, head.b, head.op; latch tag and illegal = (op >= 5); go to WAIT. Otherwise stay in IDLE.
  - WAIT: the ALU samples operands at this edge. Go to CAP.
  - CAP: rsp_result <= alu_result, rsp_tag <= latched tag, rsp_illegal <= latched flag, rsp_valid <= 1. Go to RESP.
  - RESP: hold rsp_* stable while !rsp_ready. On rsp_ready, clear rsp_valid. Then, if count != 0, pop the next head in the same edge (load alu_* regs) and go to WAIT; else go to IDLE.
- alu_a/alu_b/alu_ctrl change only on a pop and otherwise hold their last values.
- Latency: command pushed into an empty FIFO with the FSM idle at edge T -> popped at T+1, ALU samples at T+2, rsp_valid high after T+3. With rsp_ready held high, one response every 3 cycles.
- Responses are returned strictly in push order.
- Illegal opcodes are issued unchanged: the ALU yields 0, rsp_result = 0, rsp_illegal = 1.
- Arithmetic is modulo 2^WIDTH; no carry or overflow outputs.
- Simultaneous push and RESP-pop: both take effect; count is unchanged.

Test Plan:
1. Reset, then push add A=5 B=7 tag=3 at edge T -> rsp_valid rises after T+3 with rsp_result=12, rsp_tag=3, rsp_illegal=0. busy=1 from T until the response handshake, then 0.
2. Push sub A=3 B=5 tag=1, then not A=0x0F0F0F0F tag=2, with rsp_ready=1 -> responses 0xFFFFFFFE/tag1, then 0xF0F0F0F0/tag2, 3 cycles apart.
3. rsp_ready=0; push tags 0..5 with cmd_valid held -> tag0 in RESP, tags 1..4 queued, count=4, cmd_ready=0, tag5 stalls. Raise rsp_ready -> tag5 accepted; responses return in tag order 0..5.
4. Push op=110 A=1 B=1 tag=9 -> rsp_result=0, rsp_illegal=1, rsp_tag=9.
5. Hold rsp_ready=0 for 10 cycles with a response pending -> rsp_valid, rsp_result, rsp_tag stable; then one rsp_ready pulse -> rsp_valid drops next cycle.
6. Assert rst for 1 cycle while in WAIT with 2 commands queued -> next cycle all outputs 0, count=0, state IDLE, and no response appears for the dropped commands.
